// File: rtl/mfcc_melbank_rd_sched.sv
// rtl/mfcc_melbank_rd_sched.sv - round-robin burst read scheduler for the mel coefficient ROM
//
// Shares one single-port coefficient ROM between two burst requesters.
// It arbitrates round-robin, issues one ROM address per cycle while the
// response FIFO has room, and tracks the ROM read latency. It returns the
// coefficients through a first-word-fall-through FIFO tagged with id and last.
//
// Ports:
//   clk_tb, tb_rst              clock, asynchronous active-high reset
//   reqN_valid/addr/len         burst request from requester N (len 0..2^ADDR_WIDTH)
//   reqN_ready                  one-cycle accept pulse for requester N
//   rom_addr                    registered ROM read address
//   rom_rd_data                 ROM read data, valid LAT cycles after rom_addr
//   rsp_valid/data/id/last      FIFO head; popped when rsp_valid & rsp_ready
//   rsp_ready                   consumer accepts head
//   busy                        a burst is being issued or drained
//   err_len                     pulses with ready when a zero-length burst is accepted

module mfcc_melbank_rd_sched #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int OUT_REG    = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_tb,
  input  logic                  tb_rst,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [ADDR_WIDTH:0]   req0_len,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [ADDR_WIDTH:0]   req1_len,
  output logic                  req1_ready,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_id,
  output logic                  rsp_last,
  input  logic                  rsp_ready,
  output logic                  busy,
  output logic                  err_len
);

  localparam int LAT    = 1 + OUT_REG;
  // One stage for the rom_addr register plus LAT stages of ROM latency.
  localparam int PIPE_N = LAT + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W:0]      DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                  rr_ptr_q;
  logic                  req0_ready_q, req1_ready_q, err_len_q;
  logic [ADDR_WIDTH-1:0] cur_addr_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic                  cur_id_q;
  logic [ADDR_WIDTH-1:0] rom_addr_q;

  logic [PIPE_N-1:0]     pipe_vld_q, pipe_id_q, pipe_last_q;
  logic [CNT_W-1:0]      inflight_q;

  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_id_q, fifo_last_q;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      fifo_count_q;

  logic                  grant_en, grant_id;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [ADDR_WIDTH:0]   grant_len;
  logic                  issue_room, issue;
  logic                  pipe_exit, push, pop;

  // Arbitration. The ready pulse is registered, so the requester still holds
  // valid in the cycle it sees ready. Granting is suppressed in that cycle so
  // that a zero-length burst (which leaves us in IDLE) is not accepted twice.
  always_comb begin
    grant_en   = 1'b0;
    grant_id   = 1'b0;
    grant_addr = req0_addr;
    grant_len  = req0_len;
    if (state_q == S_IDLE && !req0_ready_q && !req1_ready_q) begin
      if (req0_valid && req1_valid) begin
        grant_en = 1'b1;
        grant_id = rr_ptr_q;
      end else if (req0_valid) begin
        grant_en = 1'b1;
        grant_id = 1'b0;
      end else if (req1_valid) begin
        grant_en = 1'b1;
        grant_id = 1'b1;
      end
    end
    if (grant_id) begin
      grant_addr = req1_addr;
      grant_len  = req1_len;
    end
  end

  // Room check uses the pre-pop FIFO count: words in the FIFO plus words
  // still in the ROM latency pipe must leave a free slot for the new issue.
  assign issue_room = ({1'b0, fifo_count_q} + {1'b0, inflight_q}) < DEPTH_C;

  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_en && grant_len != '0) begin
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (issue_room) begin
          issue = 1'b1;
          if (remaining_q == LEN_ONE) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (inflight_q == '0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pipe_exit = pipe_vld_q[PIPE_N-1];
  assign push      = pipe_exit;
  assign pop       = rsp_valid & rsp_ready;

  // Grant bookkeeping, address sequencing and the latency pipe.
  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      rr_ptr_q     <= 1'b0;
      req0_ready_q <= 1'b0;
      req1_ready_q <= 1'b0;
      err_len_q    <= 1'b0;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      cur_id_q     <= 1'b0;
      rom_addr_q   <= '0;
      pipe_vld_q   <= '0;
      pipe_id_q    <= '0;
      pipe_last_q  <= '0;
      inflight_q   <= '0;
    end else begin
      req0_ready_q <= grant_en && !grant_id;
      req1_ready_q <= grant_en && grant_id;
      err_len_q    <= grant_en && (grant_len == '0);

      if (grant_en) begin
        cur_addr_q  <= grant_addr;
        remaining_q <= grant_len;
        cur_id_q    <= grant_id;
        rr_ptr_q    <= ~grant_id;
      end else if (issue) begin
        rom_addr_q  <= cur_addr_q;
        cur_addr_q  <= cur_addr_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
      end

      pipe_vld_q  <= {pipe_vld_q[PIPE_N-2:0], issue};
      pipe_id_q   <= {pipe_id_q[PIPE_N-2:0], cur_id_q};
      pipe_last_q <= {pipe_last_q[PIPE_N-2:0], remaining_q == LEN_ONE};

      case ({issue, pipe_exit})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // Response FIFO control.
  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      fifo_id_q    <= '0;
      fifo_last_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q              <= wr_ptr_q + 1'b1;
        fifo_id_q[wr_ptr_q]   <= pipe_id_q[PIPE_N-1];
        fifo_last_q[wr_ptr_q] <= pipe_last_q[PIPE_N-1];
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + 1'b1;
        2'b01:   fifo_count_q <= fifo_count_q - 1'b1;
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

  // Data storage needs no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk_tb) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= rom_rd_data;
    end
  end

  assign req0_ready = req0_ready_q;
  assign req1_ready = req1_ready_q;
  assign err_len    = err_len_q;
  assign rom_addr   = rom_addr_q;
  assign busy       = (state_q != S_IDLE);
  assign rsp_valid  = (fifo_count_q != '0);
  assign rsp_data   = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign rsp_id     = rsp_valid & fifo_id_q[rd_ptr_q];
  assign rsp_last   = rsp_valid & fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_mfcc_melbank_rd_sched.sv
// tb/tb_mfcc_melbank_rd_sched.sv - scoreboard bench for mfcc_melbank_rd_sched

module tb_mfcc_melbank_rd_sched;

  localparam int AW    = 9;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk_tb;
  logic          tb_rst;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [AW:0]   req0_len, req1_len;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_rd_data;
  logic          rsp_valid, rsp_id, rsp_last, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          busy, err_len;

  mfcc_melbank_rd_sched dut (
    .clk_tb      (clk_tb),
    .tb_rst      (tb_rst),
    .req0_valid  (req0_valid),
    .req0_addr   (req0_addr),
    .req0_len    (req0_len),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_addr   (req1_addr),
    .req1_len    (req1_len),
    .req1_ready  (req1_ready),
    .rom_addr    (rom_addr),
    .rom_rd_data (rom_rd_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_id      (rsp_id),
    .rsp_last    (rsp_last),
    .rsp_ready   (rsp_ready),
    .busy        (busy),
    .err_len     (err_len)
  );

  initial begin
    clk_tb = 1'b0;
    forever #5 clk_tb = ~clk_tb;
  end

  // Single-port ROM with one cycle of read latency.
  logic [DW-1:0] rom [0:511];
  always @(posedge clk_tb) rom_rd_data <= rom[rom_addr];

  typedef struct packed {
    logic          id;
    logic          last;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t sb[$];
  int   pop_cyc[$];
  bit   grant_log[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_ready_cyc = 0;
  int   max_occ = 0;
  int   done_drv = 0;

  always @(posedge clk_tb) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a burst of len words from addr returns rom[(addr+i) mod 512]
  // in order, tagged with the requester, last set on the final word.
  task automatic expect_burst(input bit id, input logic [AW-1:0] addr, input logic [AW:0] len);
    for (int i = 0; i < int'(len); i++) begin
      rsp_t          e;
      logic [AW-1:0] a;
      a      = AW'(int'(addr) + i);
      e.id   = id;
      e.data = rom[a];
      e.last = (i == int'(len) - 1);
      sb.push_back(e);
    end
  endtask

  task automatic set_req(input bit id, input logic v, input logic [AW-1:0] a, input logic [AW:0] l);
    if (id) begin
      req1_valid = v; req1_addr = a; req1_len = l;
    end else begin
      req0_valid = v; req0_addr = a; req0_len = l;
    end
  endtask

  // Holds a request valid until it has been accepted reps times.
  task automatic post(input bit id, input logic [AW-1:0] addr, input logic [AW:0] len, input int reps);
    int got = 0;
    int waited = 0;
    @(posedge clk_tb); #1;
    set_req(id, 1'b1, addr, len);
    while (got < reps) begin
      @(negedge clk_tb);
      if (id ? req1_ready : req0_ready) begin
        got++;
        waited = 0;
        last_ready_cyc = cyc;
        grant_log.push_back(id);
        expect_burst(id, addr, len);
        check("err_len_at_accept", 32'(err_len), 32'(len == 0));
        if (len == 0) check("busy_zero_len", 32'(busy), 0);
      end else begin
        waited++;
        if (waited > 400) begin
          check("accept_timeout", 32'(waited), 0);
          break;
        end
      end
    end
    @(posedge clk_tb); #1;
    set_req(id, 1'b0, '0, '0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || busy || rsp_valid) && n < 2000) begin
      @(negedge clk_tb);
      n++;
    end
    check("drain_within_bound", 32'(n < 2000), 1);
  endtask

  task automatic scenario1_checks(input string tag);
    check({tag, "_word_count"}, pop_cyc.size(), 4);
    if (pop_cyc.size() == 4) begin
      check({tag, "_first_latency"}, pop_cyc[0] - last_ready_cyc, 3);
      check({tag, "_no_bubbles"}, pop_cyc[3] - pop_cyc[0], 3);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted response.
  initial begin
    rsp_t exp;
    int   occ;
    forever begin
      @(negedge clk_tb);
      if (!tb_rst) begin
        occ = int'(dut.fifo_count_q) + int'(dut.inflight_q);
        if (occ > max_occ) max_occ = occ;
        occ_bound: assert (occ <= DEPTH) else begin
          bad++;
          $display("FAIL fifo_occupancy: got %0d expected <= %0d", occ, DEPTH);
        end
        if (req0_ready && req1_ready) check("ready_exclusive", 1, 0);
        if (req0_ready) check("req0_ready_needs_valid", 32'(req0_valid), 1);
        if (req1_ready) check("req1_ready_needs_valid", 32'(req1_valid), 1);
        if (rsp_valid && rsp_ready) begin
          pop_cyc.push_back(cyc);
          if (sb.size() == 0) begin
            check("unexpected_rsp", 32'({rsp_id, rsp_last, rsp_data}), 32'hFFFF_FFFF);
          end else begin
            exp = sb.pop_front();
            check("rsp_id_last_data", 32'({rsp_id, rsp_last, rsp_data}), 32'(exp));
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] ra;
    int            seen;
    tb_rst    = 1'b1;
    rsp_ready = 1'b0;
    set_req(1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, '0, '0);
    for (int a = 0; a < 512; a++) rom[a] = 8'(a);

    repeat (2) @(negedge clk_tb);
    check("reset_outputs", 32'({req0_ready, req1_ready, rom_addr, rsp_valid, rsp_data,
                                rsp_id, rsp_last, busy, err_len}), 0);
    @(posedge clk_tb); #1;
    tb_rst    = 1'b0;
    rsp_ready = 1'b1;

    // Both requesters held valid from reset: grants alternate 0,1,0,1.
    grant_log.delete();
    fork
      post(1'b0, 9'h030, 10'd2, 2);
      post(1'b1, 9'h080, 10'd2, 2);
    join
    wait_drain();
    check("alt_grant_count", grant_log.size(), 4);
    for (int i = 0; i < grant_log.size(); i++) check("alt_grant_order", 32'(grant_log[i]), i % 2);

    // Single burst: latency and throughput.
    pop_cyc.delete();
    post(1'b0, 9'h010, 10'd4, 1);
    wait_drain();
    scenario1_checks("s1");

    // Address wrap at the top of the ROM.
    post(1'b1, 9'h1FE, 10'd4, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_tb);
      ra = AW'(9'h1FE + i);
      check("wrap_rom_addr", 32'(rom_addr), 32'(ra));
    end
    wait_drain();

    // Backpressure: the FIFO fills, issue stalls, nothing is lost.
    rsp_ready = 1'b0;
    max_occ   = 0;
    post(1'b0, 9'h000, 10'd8, 1);
    repeat (20) @(negedge clk_tb);
    check("bp_rom_addr_stalled", 32'(rom_addr), 3);
    check("bp_busy_held", 32'(busy), 1);
    @(posedge clk_tb); #1;
    rsp_ready = 1'b1;
    wait_drain();
    check("bp_max_occupancy", max_occ, DEPTH);

    // Zero-length request.
    post(1'b0, 9'h020, 10'd0, 1);
    @(negedge clk_tb);
    check("len0_single_pulse", 32'({req0_ready, err_len, busy}), 0);
    seen = 0;
    repeat (5) begin
      @(negedge clk_tb);
      if (busy || rsp_valid) seen++;
    end
    check("len0_quiet", seen, 0);
    post(1'b1, 9'h005, 10'd1, 1);
    wait_drain();

    // Reset in the middle of a long burst.
    post(1'b0, 9'h040, 10'd16, 1);
    @(posedge clk_tb); #1;
    @(posedge clk_tb); #1;
    tb_rst = 1'b1;
    #1;
    check("midburst_reset_outputs", 32'({req0_ready, req1_ready, rom_addr, rsp_valid, rsp_data,
                                         rsp_id, rsp_last, busy, err_len}), 0);
    sb.delete();
    repeat (2) @(posedge clk_tb);
    #1;
    tb_rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk_tb);
      if (busy || rsp_valid) seen++;
    end
    check("post_reset_quiet", seen, 0);
    pop_cyc.delete();
    post(1'b0, 9'h010, 10'd4, 1);
    wait_drain();
    scenario1_checks("after_reset");

    // Randomized traffic on both ports with random consumer stalls.
    for (int a = 0; a < 512; a++) rom[a] = 8'($urandom);
    done_drv = 0;
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          repeat ($urandom_range(0, 5)) @(posedge clk_tb);
          post(1'b0, 9'($urandom), 10'($urandom_range(0, 12)), 1);
        end
        done_drv++;
      end
      begin
        for (int k = 0; k < 10; k++) begin
          repeat ($urandom_range(0, 5)) @(posedge clk_tb);
          post(1'b1, 9'($urandom), 10'($urandom_range(0, 12)), 1);
        end
        done_drv++;
      end
      begin
        while (done_drv < 2) begin
          @(posedge clk_tb); #1;
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(posedge clk_tb); #1;
    rsp_ready = 1'b1;
    wait_drain();
    check("random_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
